// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolver datapath.
// Holds the FSM state encoding and the chunk-count calculation.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resolver_state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Operand/result handshake bundle for csa_resolver: valid/ready in, valid/ready out.
// Latency: n/a. Backpressure: out_ready stalls the producer side via in_ready.
interface csa_resolver_if #(
    parameter int WIDTH = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/chunk_adder.sv
// Purpose: one CHUNK-wide slice of the carry-propagate adder (a + b + cin).
// Latency: combinational. Backpressure: none.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
endmodule

// File: rtl/csa_resolver.sv
// Purpose: resolve a carry-save (sum, carry) pair to binary, CHUNK bits per cycle.
// Latency: NUM_CHUNKS edges from accept to out_valid. Backpressure: holds DONE until out_ready.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_resolver_if.slave bus
);
    localparam int NC = num_chunks(WIDTH, CHUNK);
    localparam int PW = NC * CHUNK;
    localparam int CW = $clog2(NC) + 1;
    localparam logic [CW-1:0] LAST_K = CW'(NC - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
            $error("csa_resolver: CHUNK must lie in 1..WIDTH");
        end
    endgenerate

    resolver_state_t r_state, w_next_state;
    logic [PW-1:0]    r_a, r_b, r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_result;

    logic [PW-1:0]    w_a_pad, w_b_pad, w_acc_next;
    logic [CHUNK-1:0] w_a_chk, w_b_chk, w_sum;
    logic             w_cout, w_in_ready, w_out_valid, w_busy, w_last;

    // B is carry shifted up one place; its top bit falls off under modulo arithmetic.
    always_comb begin
        w_a_pad              = '0;
        w_a_pad[WIDTH-1:0]   = bus.sum_in;
        w_b_pad              = '0;
        w_b_pad[WIDTH-1:1]   = bus.carry_in[WIDTH-2:0];
    end

    always_comb begin
        w_a_chk = '0;
        w_b_chk = '0;
        for (int i = 0; i < NC; i++) begin
            if (r_k == CW'(i)) begin
                w_a_chk = r_a[i*CHUNK +: CHUNK];
                w_b_chk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.W(CHUNK)) u_chunk_adder (
        .i_a    (w_a_chk),
        .i_b    (w_b_chk),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < NC; i++) begin
            if (r_k == CW'(i)) begin
                w_acc_next[i*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    assign w_last = (r_k == LAST_K);

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next_state = BUSY;
            end
            BUSY: begin
                w_busy = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // The visible result only moves when the last chunk lands, never mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_result <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_a     <= w_a_pad;
            r_b     <= w_b_pad;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
        end else if (r_state == BUSY) begin
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_k     <= r_k + CW'(1);
            if (w_last) r_result <= w_acc_next[WIDTH-1:0];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed cases plus random pairs on CHUNK=4 and CHUNK=11 instances,
// scored against (s + 2c) mod 2^11.
module tb_csa_resolver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_resolver_if #(.WIDTH(11)) bus4 ();
    csa_resolver_if #(.WIDTH(11)) bus11 ();

    csa_resolver #(.WIDTH(11), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    csa_resolver #(.WIDTH(11), .CHUNK(11)) dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model(input logic [10:0] s, input logic [10:0] c);
        int unsigned v;
        v = int'(s) + 2 * int'(c);
        return 11'(v % 2048);
    endfunction

    task automatic set_in(input int w, input logic v, input logic [10:0] s, input logic [10:0] c);
        if (w == 0) begin
            bus4.in_valid = v; bus4.sum_in = s; bus4.carry_in = c;
        end else begin
            bus11.in_valid = v; bus11.sum_in = s; bus11.carry_in = c;
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 0) bus4.out_ready = r;
        else        bus11.out_ready = r;
    endtask

    // {in_ready, out_valid, busy}
    function automatic logic [2:0] flags(input int w);
        if (w == 0) return {bus4.in_ready, bus4.out_valid, bus4.busy};
        return {bus11.in_ready, bus11.out_valid, bus11.busy};
    endfunction

    function automatic logic [10:0] res(input int w);
        return (w == 0) ? bus4.result : bus11.result;
    endfunction

    // One full transaction; hold > 0 keeps out_ready low in DONE while pushing junk on in_valid.
    task automatic run_op(input int w, input logic [10:0] s, input logic [10:0] c, input int hold,
                          output logic [10:0] r, output int lat, output int nbusy, output int toggles);
        logic [10:0] prev;
        int t;
        @(negedge clk);
        set_ordy(w, 1'b0);
        set_in(w, 1'b1, s, c);
        t = 0;
        while (!flags(w)[2] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'(flags(w)[2]), 32'd1);
        prev = res(w);
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, 11'h0, 11'h0);
        lat = 0; nbusy = 0; toggles = 0;
        while (!flags(w)[1] && lat < 40) begin
            if (flags(w)[0]) nbusy++;
            if (res(w) !== prev) toggles++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check("done_timeout", 32'(flags(w)[1]), 32'd1);
        r = res(w);
        for (int i = 0; i < hold; i++) begin
            set_in(w, 1'b1, 11'h123 + 11'(i), 11'h055);
            @(negedge clk);
            check("bp_flags", 32'(flags(w)), 32'b010);
            check("bp_result", 32'(res(w)), 32'(r));
        end
        set_in(w, 1'b0, 11'h0, 11'h0);
        set_ordy(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(w, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] r, s, c;
        int lat, nbusy, tog, hold;

        rst_n = 1'b0;
        set_in(0, 1'b0, 11'h0, 11'h0);
        set_in(1, 1'b0, 11'h0, 11'h0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        #1;
        check("rst_flags4", 32'(flags(0)), 32'b100);
        check("rst_res4", 32'(res(0)), 32'h0);
        check("rst_flags11", 32'(flags(1)), 32'b100);
        check("rst_res11", 32'(res(1)), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 11'h005, 11'h003, 0, r, lat, nbusy, tog);
        check("basic_res", 32'(r), 32'h00B);
        check("basic_lat", 32'(lat), 32'd3);
        check("basic_busy", 32'(nbusy), 32'd3);
        check("basic_idle", 32'(flags(0)), 32'b100);

        run_op(0, 11'h7FF, 11'h001, 0, r, lat, nbusy, tog);
        check("ripple_res", 32'(r), 32'h001);
        check("ripple_tog", 32'(tog), 32'd0);

        run_op(0, 11'h7FE, 11'h7FF, 5, r, lat, nbusy, tog);
        check("neg_res", 32'(r), 32'h7FC);
        check("bp_idle_flags", 32'(flags(0)), 32'b100);
        check("bp_idle_res", 32'(res(0)), 32'h7FC);

        // Reset while the second chunk is being resolved.
        @(negedge clk);
        set_in(0, 1'b1, 11'h155, 11'h0AA);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 11'h0, 11'h0);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(flags(0)), 32'b001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 32'(flags(0)), 32'b100);
        check("mid_rst_res", 32'(res(0)), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 11'h010, 11'h008, 0, r, lat, nbusy, tog);
        check("post_rst_res", 32'(r), 32'h020);
        check("post_rst_lat", 32'(lat), 32'd3);

        run_op(1, 11'h400, 11'h200, 0, r, lat, nbusy, tog);
        check("c11_res", 32'(r), 32'h000);
        check("c11_lat", 32'(lat), 32'd1);
        check("c11_busy", 32'(nbusy), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            s = 11'($urandom);
            c = 11'($urandom);
            hold = (($urandom & 7) == 0) ? 1 : 0;
            run_op(1, s, c, hold, r, lat, nbusy, tog);
            check("rnd11_res", 32'(r), 32'(model(s, c)));
            check("rnd11_lat", 32'(lat), 32'd1);
        end

        for (int i = 0; i < 300; i++) begin
            s = 11'($urandom);
            c = 11'($urandom);
            hold = int'($urandom_range(0, 2));
            run_op(0, s, c, hold, r, lat, nbusy, tog);
            check("rnd4_res", 32'(r), 32'(model(s, c)));
            check("rnd4_lat", 32'(lat), 32'd3);
            check("rnd4_tog", 32'(tog), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
